halli_galli_core_n: RTL and testbench

Parametrised N-player Halli Galli game core. It sits between the keypad/turn front end and the display/LCD back end. It accepts flip and bell events, keeps one face-up top card per player, judges bells against a configurable target sum, and keeps per-player scores, the shared pile and the dealt-card count. It replaces the fixed two-player turn, counter, demux, is_right, who_push and score_control chain with one sequential block.

---
 rtl/halli_galli_core_n.sv | 270 +++++++++++++++++++++++++++
 tb/tb_halli_galli_core_n.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halli_galli_core_n.sv
// ---------------------------------------------------------------------------
// halli_galli_core_n
//
// N-player Halli Galli game core. It accepts flip and bell events from the
// keypad/turn front end. It keeps one face-up top card per player and judges
// each bell against a target same-colour sum. It keeps per-player scores, the
// shared pile and the dealt-card count for the display back end.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flip                one-cycle pulse: current player turns a card
//   card_color/num      card sampled with flip
//   bell[NPLAYER]       one-cycle bell presses, bit i = player i
//   turn                player whose flip is next
//   top_valid/color/num face-up card per slot (packed, slot i at low index)
//   score               packed unsigned per-player scores
//   dealt, pile         cards flipped so far / cards on the table
//   res_valid/ok/who    one-cycle bell verdict
//   game_over, winner, tie   end-of-game result (winner/tie valid in OVER)
//   fsm_state           debug view of the game state machine
//
// Handshake: flip and bell are single-cycle strobes with no back-pressure.
// An event is either consumed on the edge that samples it or dropped. A bell
// wins over a flip in the same cycle. Both are dropped during JUDGE and OVER.
// ---------------------------------------------------------------------------
module halli_galli_core_n #(
    parameter int NPLAYER = 2,
    parameter int TARGET  = 5,
    parameter int MAXNUM  = 5,
    parameter int DECK    = 56,
    parameter int END_CYC = 1000,
    localparam int PW = (NPLAYER > 2) ? $clog2(NPLAYER) : 1,
    localparam int DW = $clog2(DECK + 1),
    localparam int SW = DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flip,
    input  logic [1:0]             card_color,
    input  logic [2:0]             card_num,
    input  logic [NPLAYER-1:0]     bell,
    output logic [PW-1:0]          turn,
    output logic [NPLAYER-1:0]     top_valid,
    output logic [2*NPLAYER-1:0]   top_color,
    output logic [3*NPLAYER-1:0]   top_num,
    output logic [NPLAYER*SW-1:0]  score,
    output logic [DW-1:0]          dealt,
    output logic [DW-1:0]          pile,
    output logic                   res_valid,
    output logic                   res_ok,
    output logic [PW-1:0]          res_who,
    output logic                   game_over,
    output logic [PW-1:0]          winner,
    output logic                   tie,
    output logic [1:0]             fsm_state
);

    localparam int CW = (END_CYC < 1) ? 1 : $clog2(END_CYC + 1);

    localparam logic [DW-1:0] DECK_W   = DW'(DECK);
    localparam logic [SW-1:0] PENALTY  = SW'(NPLAYER - 1);
    localparam logic [2:0]    MAXNUM_W = 3'(MAXNUM);
    localparam logic [4:0]    TARGET_W = 5'(TARGET);
    localparam logic [PW-1:0] LAST_P   = PW'(NPLAYER - 1);
    localparam logic [CW-1:0] END_W    = CW'(END_CYC);

    typedef enum logic [1:0] {
        S_PLAY   = 2'd0,
        S_JUDGE  = 2'd1,
        S_ENDWIN = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   who;        // bell owner latched for the JUDGE cycle
    logic [CW-1:0]   win_cnt;    // end-phase bell window down-counter

    // ---------------- event decode ----------------
    logic            any_bell;
    logic [PW-1:0]   bell_idx;
    logic            flip_ok;
    logic [DW-1:0]   dealt_inc;
    logic [2:0]      num_clamped;
    logic [PW-1:0]   turn_inc;

    assign any_bell  = |bell;
    assign flip_ok   = flip && (dealt < DECK_W);
    assign dealt_inc = dealt + 1'b1;
    assign turn_inc  = (turn == LAST_P) ? '0 : turn + 1'b1;

    // Lowest set bell index wins; scan high to low so the last write is lowest.
    always_comb begin
        bell_idx = '0;
        for (int i = NPLAYER - 1; i >= 0; i--) begin
            if (bell[i]) begin
                bell_idx = PW'(i);
            end
        end
    end

    always_comb begin
        num_clamped = card_num;
        if (card_num == 3'd0) begin
            num_clamped = 3'd1;
        end else if (card_num > MAXNUM_W) begin
            num_clamped = MAXNUM_W;
        end
    end

    // ---------------- bell judgement ----------------
    // 5-bit sums hold 4 slots x 7 without overflow.
    logic [4:0] csum [4];
    logic       bell_ok;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            csum[c] = '0;
            for (int i = 0; i < NPLAYER; i++) begin
                if (top_valid[i] && (top_color[2*i +: 2] == 2'(c))) begin
                    csum[c] = csum[c] + {2'b00, top_num[3*i +: 3]};
                end
            end
        end
    end

    always_comb begin
        bell_ok = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (csum[c] == TARGET_W) begin
                bell_ok = 1'b1;
            end
        end
    end

    logic [SW-1:0] who_score;
    logic [SW-1:0] score_add;
    logic [SW-1:0] score_sub;

    assign who_score = score[who*SW +: SW];
    assign score_add = who_score + pile;
    // The penalty never takes a score below zero.
    assign score_sub = who_score - ((who_score < PENALTY) ? who_score : PENALTY);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_PLAY;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_PLAY: begin
                if (any_bell) begin
                    state_next = S_JUDGE;
                end else if (flip_ok && (dealt_inc == DECK_W)) begin
                    state_next = S_ENDWIN;
                end
            end
            S_JUDGE: begin
                state_next = (dealt == DECK_W) ? S_ENDWIN : S_PLAY;
            end
            S_ENDWIN: begin
                // A bell pauses the window; the count resumes after JUDGE.
                if (any_bell) begin
                    state_next = S_JUDGE;
                end else if (win_cnt <= CW'(1)) begin
                    state_next = S_OVER;
                end
            end
            default: begin
                state_next = S_OVER;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic [PW-1:0] best_idx;
    logic [SW-1:0] best_score;
    logic [SW-1:0] cur_score;
    logic          best_tied;

    always_comb begin
        best_idx   = '0;
        best_score = score[0 +: SW];
        best_tied  = 1'b0;
        cur_score  = '0;
        for (int i = 1; i < NPLAYER; i++) begin
            cur_score = score[i*SW +: SW];
            if (cur_score > best_score) begin
                best_score = cur_score;
                best_idx   = PW'(i);
                best_tied  = 1'b0;
            end else if (cur_score == best_score) begin
                best_tied = 1'b1;
            end
        end
    end

    always_comb begin
        game_over = (state == S_OVER);
        winner    = game_over ? best_idx : '0;
        tie       = game_over && best_tied;
        fsm_state = state;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            turn      <= '0;
            top_valid <= '0;
            top_color <= '0;
            top_num   <= '0;
            score     <= '0;
            dealt     <= '0;
            pile      <= '0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_who   <= '0;
            who       <= '0;
            win_cnt   <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_PLAY: begin
                    if (any_bell) begin
                        who <= bell_idx;
                    end else if (flip_ok) begin
                        top_valid[turn]        <= 1'b1;
                        top_color[2*turn +: 2] <= card_color;
                        top_num[3*turn +: 3]   <= num_clamped;
                        turn                   <= turn_inc;
                        dealt                  <= dealt_inc;
                        pile                   <= pile + 1'b1;
                        if (dealt_inc == DECK_W) begin
                            win_cnt <= END_W;
                        end
                    end
                end
                S_JUDGE: begin
                    res_valid <= 1'b1;
                    res_ok    <= bell_ok;
                    res_who   <= who;
                    if (bell_ok) begin
                        score[who*SW +: SW] <= score_add;
                        pile                <= '0;
                        top_valid           <= '0;
                    end else begin
                        score[who*SW +: SW] <= score_sub;
                    end
                end
                S_ENDWIN: begin
                    if (any_bell) begin
                        who <= bell_idx;
                    end else if (win_cnt != '0) begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halli_galli_core_n.sv
// ---------------------------------------------------------------------------
// Self-checking bench for halli_galli_core_n (4 players, 12-card deck,
// 6-cycle end window). A game-level reference model runs alongside the DUT.
// It tracks the table, scores and a pending-bell flag as plain integers.
// A queue of predicted bell verdicts is matched against every res_valid pulse.
// ---------------------------------------------------------------------------
module tb_halli_galli_core_n;

    localparam int NP   = 4;
    localparam int TGT  = 5;
    localparam int MAXN = 5;
    localparam int DK   = 12;
    localparam int EC   = 6;
    localparam int PW   = 2;
    localparam int DW   = 4;
    localparam int SW   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                flip = 1'b0;
    logic [1:0]          card_color = '0;
    logic [2:0]          card_num = '0;
    logic [NP-1:0]       bell = '0;
    logic [PW-1:0]       turn;
    logic [NP-1:0]       top_valid;
    logic [2*NP-1:0]     top_color;
    logic [3*NP-1:0]     top_num;
    logic [NP*SW-1:0]    score;
    logic [DW-1:0]       dealt;
    logic [DW-1:0]       pile;
    logic                res_valid;
    logic                res_ok;
    logic [PW-1:0]       res_who;
    logic                game_over;
    logic [PW-1:0]       winner;
    logic                tie;
    logic [1:0]          fsm_state;

    halli_galli_core_n #(
        .NPLAYER(NP), .TARGET(TGT), .MAXNUM(MAXN), .DECK(DK), .END_CYC(EC)
    ) u_dut (
        .clk(clk), .rst(rst), .flip(flip), .card_color(card_color),
        .card_num(card_num), .bell(bell), .turn(turn), .top_valid(top_valid),
        .top_color(top_color), .top_num(top_num), .score(score),
        .dealt(dealt), .pile(pile), .res_valid(res_valid), .res_ok(res_ok),
        .res_who(res_who), .game_over(game_over), .winner(winner), .tie(tie),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];   // predicted {ok, who} per accepted bell

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_turn, m_dealt, m_pile, m_win, m_who, m_rwho;
    int m_valid[NP], m_col[NP], m_num[NP], m_score[NP];
    bit m_over, m_judge, m_rv, m_ok;

    task automatic model_reset();
        m_turn = 0; m_dealt = 0; m_pile = 0; m_win = 0; m_who = 0; m_rwho = 0;
        m_over = 0; m_judge = 0; m_rv = 0; m_ok = 0;
        for (int i = 0; i < NP; i++) begin
            m_valid[i] = 0; m_col[i] = 0; m_num[i] = 0; m_score[i] = 0;
        end
        exp_q.delete();
    endtask

    function automatic bit table_hits_target();
        int sums[4];
        bit hit;
        for (int c = 0; c < 4; c++) sums[c] = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_valid[i] != 0) sums[m_col[i]] += m_num[i];
        end
        hit = 0;
        for (int c = 0; c < 4; c++) begin
            if (sums[c] == TGT) hit = 1;
        end
        return hit;
    endfunction

    function automatic int clamp_num(input int n);
        if (n == 0) return 1;
        if (n > MAXN) return MAXN;
        return n;
    endfunction

    task automatic model_step(input bit f, input int col, input int num, input logic [NP-1:0] b);
        int lo;
        m_rv = 0;
        if (m_judge) begin
            m_judge = 0;
            m_rv = 1;
            m_ok = table_hits_target();
            m_rwho = m_who;
            if (m_ok) begin
                m_score[m_who] += m_pile;
                m_pile = 0;
                for (int i = 0; i < NP; i++) m_valid[i] = 0;
            end else begin
                m_score[m_who] -= (m_score[m_who] < NP - 1) ? m_score[m_who] : NP - 1;
            end
        end else if (m_over) begin
            // inputs ignored until reset
        end else if (b != 0) begin
            lo = 0;
            for (int i = NP - 1; i >= 0; i--) if (b[i]) lo = i;
            m_who = lo;
            m_judge = 1;
            exp_q.push_back({5'b0, table_hits_target(), 2'(lo)});
        end else if (m_dealt == DK) begin
            if (m_win <= 1) m_over = 1;
            else m_win--;
        end else if (f) begin
            m_valid[m_turn] = 1;
            m_col[m_turn] = col;
            m_num[m_turn] = clamp_num(num);
            m_turn = (m_turn + 1) % NP;
            m_dealt++;
            m_pile++;
            if (m_dealt == DK) m_win = EC;
        end
    endtask

    task automatic compare_all();
        logic [7:0] e;
        int best, best_i, n_best;
        for (int i = 0; i < NP; i++) begin
            check($sformatf("top_valid%0d", i), int'(top_valid[i]), m_valid[i]);
            check($sformatf("top_color%0d", i), int'(top_color[2*i +: 2]), m_col[i]);
            check($sformatf("top_num%0d", i), int'(top_num[3*i +: 3]), m_num[i]);
            check($sformatf("score%0d", i), int'(score[SW*i +: SW]), m_score[i]);
        end
        check("turn", int'(turn), m_turn);
        check("dealt", int'(dealt), m_dealt);
        check("pile", int'(pile), m_pile);
        check("res_valid", int'(res_valid), int'(m_rv));
        check("res_ok", int'(res_ok), int'(m_ok));
        check("res_who", int'(res_who), m_rwho);
        check("game_over", int'(game_over), int'(m_over));
        best = -1; best_i = 0; n_best = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_score[i] > best) begin best = m_score[i]; best_i = i; n_best = 1; end
            else if (m_score[i] == best) n_best++;
        end
        check("winner", int'(winner), m_over ? best_i : 0);
        check("tie", int'(tie), (m_over && n_best > 1) ? 1 : 0);
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                check("verdict_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("verdict", int'({res_ok, res_who}), int'(e[2:0]));
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit f, input int col, input int num,
                        input logic [NP-1:0] b, input bit r);
        flip = f; card_color = 2'(col); card_num = 3'(num); bell = b; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else model_step(f, col, num, b);
        #1;
        compare_all();
        flip = 1'b0; bell = '0; rst = 1'b0;
    endtask

    task automatic do_reset();
        step(0, 0, 0, '0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(posedge clk);
        do_reset();
        do_reset();

        // Flip sequence: slots 0..2 = (red,2) (green,3) (red,3)
        step(1, 0, 2, '0, 0);
        step(1, 1, 3, '0, 0);
        step(1, 0, 3, '0, 0);
        check("dir_turn_after_3", int'(turn), 3);
        check("dir_dealt_3", int'(dealt), 3);

        // Correct bell by player 2: red 2+3 = 5
        step(0, 0, 0, 4'b0100, 0);
        step(0, 0, 0, '0, 0);
        check("dir_ok", int'(res_ok), 1);
        check("dir_score2", int'(score[2*SW +: SW]), 3);
        check("dir_pile0", int'(pile), 0);

        // Wrong bell by player 0 with score 0 saturates
        step(1, 1, 2, '0, 0);
        step(0, 0, 0, 4'b0001, 0);
        step(0, 0, 0, '0, 0);
        check("dir_wrong_sat", int'(score[0 +: SW]), 0);

        // Flip together with bell: flip dropped, player 1 judged
        step(1, 2, 4, 4'b1010, 0);
        check("dir_sim_dealt", int'(dealt), 4);
        step(0, 0, 0, '0, 0);
        check("dir_sim_who", int'(res_who), 1);

        // Build score0 = 4 then a wrong bell takes 3 (NPLAYER-1)
        step(1, 1, 1, '0, 0);
        step(1, 0, 1, '0, 0);
        step(1, 1, 2, '0, 0);
        step(0, 0, 0, 4'b0001, 0);
        step(0, 0, 0, '0, 0);
        check("dir_score0_4", int'(score[0 +: SW]), 4);
        step(1, 0, 4, '0, 0);
        step(0, 0, 0, 4'b0001, 0);
        step(0, 0, 0, '0, 0);
        check("dir_penalty", int'(score[0 +: SW]), 1);

        // Clamp: slot0 gets 0 -> 1, slot1 gets 7 -> 5
        step(1, 3, 0, '0, 0);
        check("dir_clamp_lo", int'(top_num[2:0]), 1);
        step(1, 3, 7, '0, 0);
        check("dir_clamp_hi", int'(top_num[5:3]), 5);

        // Last two cards, then the end window runs out
        step(1, 2, 1, '0, 0);
        step(1, 2, 1, '0, 0);
        idle(EC - 1);
        check("dir_not_over_yet", int'(game_over), 0);
        idle(1);
        check("dir_over", int'(game_over), 1);
        step(1, 0, 3, 4'b1111, 0);
        do_reset();
        check("dir_rst_over", int'(game_over), 0);

        // All-zero scores at the end: tie, lowest index wins
        for (int i = 0; i < DK; i++) step(1, i % 4, i % 6, '0, 0);
        idle(EC);
        check("dir_tie", int'(tie), 1);
        check("dir_tie_winner", int'(winner), 0);

        // Reset landing on the JUDGE cycle
        do_reset();
        step(1, 0, 5, '0, 0);
        step(0, 0, 0, 4'b0001, 0);
        do_reset();
        check("dir_rst_judge", int'(res_valid), 0);

        // Randomised games
        for (int g = 0; g < 12; g++) begin
            do_reset();
            for (int c = 0; c < 400 && !m_over; c++) begin
                step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                     ($urandom_range(0, 7) == 0) ? NP'($urandom_range(1, 2**NP - 1)) : '0,
                     $urandom_range(0, 249) == 0);
            end
            check("rnd_game_ended", int'(m_over), 1);
            for (int c = 0; c < 4; c++) begin
                step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                     NP'($urandom_range(0, 2**NP - 1)), 0);
            end
        end

        check("verdicts_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
